// File: rtl/com_pkg.sv
// Shared constants for the FPGA<->Pico serial link (transmit and receive paths).
package com_pkg;
  localparam int DATA_W    = 16;
  localparam int BIT_CNT_W = $clog2(DATA_W) + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
endpackage

// File: rtl/com_tx_fifo.sv
// Parametric synchronous first-word-fall-through FIFO: rd_data shows the head word
// whenever empty is low; pop consumes it.
module com_tx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pushes while full and pops while empty are dropped; pointers wrap as DEPTH is a power of two.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
    else if (do_pop && !do_push) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/com_tx_spi.sv
// FPGA-to-Pico serial transmitter: buffers 16-bit words and shifts them out MSB-first
// on a divided clock, framed by an active-high window.
module com_tx_spi
  import com_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic                          clk_25mhz,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          com_sclk_out,
  output logic                          com_mosi_out,
  output logic                          com_active_out,
  output logic                          busy,
  output logic                          word_done,
  output logic [2:0]                    dbg_state
);
  // Handshake: a word transfers on every clk_25mhz edge where tx_valid && tx_ready;
  // tx_ready depends only on FIFO fullness, never on tx_valid.
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]    shreg_q, shreg_d;
  logic                 sclk_q, sclk_d, mosi_q, mosi_d, active_q, active_d;
  logic                 word_done_q, word_done_d;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic                 div_hit, gap_hit, start_word, load_word;
  logic [DATA_W-1:0]    fifo_rd_data;

  com_tx_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_25mhz),
    .reset   (reset),
    .push    (tx_valid),
    .wr_data (tx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign div_hit = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign gap_hit = (cnt_q == CNT_W'(GAP_CYCLES - 1));

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      active_q    <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      active_q    <= active_d;
      word_done_q <= word_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    active_d    = active_q;
    word_done_d = 1'b0;
    start_word  = 1'b0;
    load_word   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sclk_d   = 1'b0;
        mosi_d   = 1'b0;
        active_d = 1'b0;
        start_word = !fifo_empty;
      end
      ST_SETUP: begin
        if (div_hit) begin
          sclk_d    = 1'b1;
          bit_cnt_d = BIT_CNT_W'(1);
          cnt_d     = '0;
          state_d   = ST_SHIFT;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_SHIFT: begin
        if (!div_hit) cnt_d = cnt_q + CNT_W'(1);
        else begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == BIT_CNT_W'(DATA_W)) begin
              word_done_d = 1'b1;
              if (!fifo_empty) begin
                load_word = 1'b1;
                bit_cnt_d = '0;
              end else begin
                mosi_d  = 1'b0;
                state_d = ST_HOLD;
              end
            end else begin
              shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
              mosi_d  = shreg_q[DATA_W-2];
            end
          end
        end
      end
      ST_HOLD: begin
        if (div_hit) begin
          active_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_GAP;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_GAP: begin
        // A waiting word starts straight from the last gap cycle so the low window is exactly GAP_CYCLES.
        if (gap_hit) begin
          cnt_d      = '0;
          state_d    = ST_IDLE;
          start_word = !fifo_empty;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_word) begin
      load_word = 1'b1;
      active_d  = 1'b1;
      cnt_d     = '0;
      state_d   = ST_SETUP;
    end
    fifo_pop = load_word;
    if (load_word) begin
      shreg_d = fifo_rd_data;
      mosi_d  = fifo_rd_data[DATA_W-1];
    end
  end

  always_comb begin
    busy           = (state_q != ST_IDLE);
    dbg_state      = state_q;
    tx_ready       = !fifo_full;
    com_sclk_out   = sclk_q;
    com_mosi_out   = mosi_q;
    com_active_out = active_q;
    word_done      = word_done_q;
  end
endmodule

// File: tb/tb_com_tx_spi.sv
// Bench for com_tx_spi: random and directed pushes, words rebuilt from the serial pins
// and compared against a queue of accepted words plus timing rules.
module tb_com_tx_spi;
  import com_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_CYCLES = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk_25mhz = 1'b0;
  logic              reset     = 1'b1;
  logic [DATA_W-1:0] tx_data   = '0;
  logic              tx_valid  = 1'b0;
  logic              tx_ready;
  logic [LVL_W-1:0]  fifo_level;
  logic              com_sclk_out, com_mosi_out, com_active_out, busy, word_done;
  logic [2:0]        dbg_state;

  com_tx_spi #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk_25mhz      (clk_25mhz),
    .reset          (reset),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .fifo_level     (fifo_level),
    .com_sclk_out   (com_sclk_out),
    .com_mosi_out   (com_mosi_out),
    .com_active_out (com_active_out),
    .busy           (busy),
    .word_done      (word_done),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #20 clk_25mhz = ~clk_25mhz;

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish within 60000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0, errors = 0;
  int cyc = 0;
  logic [DATA_W-1:0] exp_q[$];
  int done_hist[$];
  bit pend_push = 0;
  int last_push_edge = 0, acc_total = 0;
  logic prev_sclk = 0, prev_active = 0, prev_done = 0;
  logic [DATA_W-1:0] bits = '0;
  int rise_cnt = 0, win_rises = 0, last_win_rises = 0;
  int done_cnt = 0, fall_cnt = 0, arise_cnt = 0;
  int act_rise_cyc = 0, act_fall_cyc = 0, low_len = 0, lvl = 0;
  bit have_fall = 0, saw_full = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor: samples 2ns after each active edge ----------------
  always @(posedge clk_25mhz) begin
    int pop_e;
    cyc++;
    #2;
    if (reset) begin
      prev_sclk = 0; prev_active = 0; prev_done = 0;
      rise_cnt = 0; win_rises = 0; lvl = 0; have_fall = 0; bits = '0;
    end else begin
      pop_e = 0;
      if (com_sclk_out && !prev_sclk) begin
        bits = {bits[DATA_W-2:0], com_mosi_out};
        rise_cnt++;
        win_rises++;
        chk("active_at_rise", int'(com_active_out), 1);
      end
      if (com_active_out && !prev_active) begin
        act_rise_cyc = cyc;
        arise_cnt++;
        if (have_fall) low_len = cyc - act_fall_cyc;
        win_rises = 0;
        pop_e = 1;
      end
      if (!com_active_out && prev_active) begin
        act_fall_cyc = cyc;
        fall_cnt++;
        last_win_rises = win_rises;
        have_fall = 1;
      end
      if (word_done) begin
        chk("done_one_cycle", int'(prev_done), 0);
        chk("sclk_low_at_done", int'(com_sclk_out), 0);
        chk("rises_per_word", rise_cnt, DATA_W);
        if (exp_q.size() == 0) chk("unexpected_word", int'(bits), -1);
        else chk("word_data", int'(bits), int'(exp_q.pop_front()));
        done_cnt++;
        done_hist.push_back(cyc);
        rise_cnt = 0;
        if (lvl > 0) pop_e = 1;
      end
      lvl = lvl + (pend_push ? 1 : 0) - pop_e;
      chk("fifo_level", int'(fifo_level), lvl);
      chk("tx_ready", int'(tx_ready), int'(lvl < FIFO_DEPTH));
      if (lvl == FIFO_DEPTH) saw_full = 1;
      prev_sclk   = com_sclk_out;
      prev_active = com_active_out;
      prev_done   = word_done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [DATA_W-1:0] d);
    @(negedge clk_25mhz);
    tx_data   = d;
    tx_valid  = 1'b1;
    pend_push = tx_ready;
    if (tx_ready) begin
      exp_q.push_back(d);
      acc_total++;
    end
    last_push_edge = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_25mhz);
      tx_valid  = 1'b0;
      pend_push = 1'b0;
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int t = 0;
    while (done_cnt < target && t < budget) begin @(negedge clk_25mhz); t++; end
    chk("wait_word_done", int'(done_cnt >= target), 1);
  endtask

  task automatic wait_fall(input int target, input int budget);
    int t = 0;
    while (fall_cnt < target && t < budget) begin @(negedge clk_25mhz); t++; end
    chk("wait_active_fall", int'(fall_cnt >= target), 1);
  endtask

  task automatic wait_arise(input int target, input int budget);
    int t = 0;
    while (arise_cnt < target && t < budget) begin @(negedge clk_25mhz); t++; end
    chk("wait_active_rise", int'(arise_cnt >= target), 1);
  endtask

  task automatic wait_rises(input int target, input int budget);
    int t = 0;
    while (rise_cnt < target && t < budget) begin @(negedge clk_25mhz); t++; end
    chk("wait_sclk_rises", int'(rise_cnt >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (!(busy == 1'b0 && fifo_level == '0 && exp_q.size() == 0) && t < budget) begin
      @(negedge clk_25mhz); t++;
    end
    chk("wait_idle", int'(t < budget), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, d0, f0, a0;
    repeat (3) @(negedge clk_25mhz);
    chk("rst_sclk", int'(com_sclk_out), 0);
    chk("rst_mosi", int'(com_mosi_out), 0);
    chk("rst_active", int'(com_active_out), 0);
    chk("rst_word_done", int'(word_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tx_ready", int'(tx_ready), 1);
    chk("rst_fifo_level", int'(fifo_level), 0);
    @(negedge clk_25mhz);
    reset = 1'b0;
    idle(2);

    // Single word timing
    d0 = done_cnt; f0 = fall_cnt;
    push_word(16'hA5C3);
    n = last_push_edge;
    idle(1);
    wait_done(d0 + 1, 300);
    wait_fall(f0 + 1, 50);
    chk("t1_active_rise", act_rise_cyc, n + 1);
    chk("t1_word_done", done_hist[done_hist.size()-1], n + 1 + 32 * CLK_DIV);
    chk("t1_active_fall", act_fall_cyc, n + 1 + 33 * CLK_DIV);
    chk("t1_rises", last_win_rises, DATA_W);
    wait_idle(100);

    // Two separate words
    push_word(16'h1234); idle(1); wait_idle(300);
    push_word(16'hFFFF); idle(1); wait_idle(300);

    // Burst of three
    d0 = done_cnt; f0 = fall_cnt;
    push_word(16'h0001); push_word(16'h8000); push_word(16'h0000);
    idle(1);
    wait_done(d0 + 3, 600);
    wait_idle(100);
    chk("t3_spacing1", done_hist[d0+1] - done_hist[d0], 2 * DATA_W * CLK_DIV);
    chk("t3_spacing2", done_hist[d0+2] - done_hist[d0+1], 2 * DATA_W * CLK_DIV);
    chk("t3_single_fall", fall_cnt - f0, 1);
    chk("t3_rises", last_win_rises, 3 * DATA_W);

    // Word pushed during HOLD waits out the gap
    d0 = done_cnt;
    push_word(DATA_W'($urandom));
    idle(1);
    wait_done(d0 + 1, 300);
    a0 = arise_cnt;
    push_word(DATA_W'($urandom));
    idle(1);
    wait_arise(a0 + 1, 50);
    chk("t6_gap_low", low_len, GAP_CYCLES);
    wait_idle(300);

    // Full FIFO with continuous valid
    d0 = done_cnt; a0 = acc_total; saw_full = 0;
    for (int i = 0; i < 40; i++) push_word(DATA_W'(16'h3000 + i));
    idle(1);
    wait_idle(3000);
    chk("t4_saw_full", int'(saw_full), 1);
    chk("t4_sent_count", done_cnt - d0, acc_total - a0);

    // Reset in the middle of a word
    push_word(DATA_W'($urandom));
    push_word(DATA_W'($urandom));
    idle(1);
    wait_rises(7, 200);
    @(negedge clk_25mhz);
    reset = 1'b1;
    #1;
    chk("t5_sclk", int'(com_sclk_out), 0);
    chk("t5_mosi", int'(com_mosi_out), 0);
    chk("t5_active", int'(com_active_out), 0);
    chk("t5_fifo_level", int'(fifo_level), 0);
    chk("t5_tx_ready", int'(tx_ready), 1);
    chk("t5_busy", int'(busy), 0);
    exp_q.delete();
    repeat (2) @(negedge clk_25mhz);
    reset = 1'b0;
    idle(2);
    d0 = done_cnt;
    push_word(16'h5A5A);
    idle(1);
    wait_idle(400);
    chk("t5_words_after_reset", done_cnt - d0, 1);

    // Random traffic
    for (int k = 0; k < 8; k++) begin
      push_word(DATA_W'($urandom));
      idle($urandom_range(1, 200));
    end
    wait_idle(3000);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/com_tx_spi.md
Name: com_tx_spi

Overview:
- Serial transmitter that returns 16-bit audio words from the FPGA to the Pico over a three-wire link: clock, data and active-window.
- FPGA is the initiator: it generates com_sclk_out, drives com_mosi_out MSB-first (changed on sclk fall, stable across sclk rise) and frames transfers with active-high com_active_out.
- Matches the framing of the existing Pico-to-FPGA receive path, so a loopback through that receiver reproduces each word.
- Holds a small FIFO so the audio pipeline can push samples without waiting on the link.

Parameters:
- CLK_DIV, 4, clk_25mhz cycles per sclk half-period; must be ≥2 (sclk = 25 MHz / (2·CLK_DIV)).
- FIFO_DEPTH, 4, word capacity of the transmit FIFO; power of two, ≥2.
- GAP_CYCLES, 4, minimum cycles com_active_out stays low between bursts; ≥1.

Ports:
- clk_25mhz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  16  word to send.
- tx_valid  in  1  tx_data is valid; the word is accepted on a cycle where tx_valid && tx_ready.
- tx_ready  out  1  equals !fifo_full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words currently in the FIFO.
- com_sclk_out  out  1  serial clock to the Pico; idles low.
- com_mosi_out  out  1  serial data, MSB-first.
- com_active_out  out  1  transfer window, active high.
- busy  out  1  high in every state except IDLE.
- word_done  out  1  one-cycle pulse coinciding with the sclk fall that follows the 16th rise.

Behaviour:
- Reset, asynchronous:
  - All outputs 0, except tx_ready = 1.
  - FIFO emptied, FSM to IDLE.
  - A partially sent word is discarded with no completion.
  - First activity after reset release requires a new push.
- FIFO:
  - Synchronous, first-word-fall-through.
  - Push when tx_valid && tx_ready. A push while full is ignored, and tx_ready is already low in that case.
  - Push and pop in the same cycle: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP. A single divider counter counts CLK_DIV cycles per phase.
- IDLE:
  - Outputs: sclk = 0, active = 0, mosi = 0.
  - If the FIFO is non-empty: pop into a 16-bit shift register, set active = 1 and mosi = bit15, go to SETUP.
  - A word pushed at edge N is popped, with active rising, at edge N+1.
- SETUP: hold for CLK_DIV cycles, then sclk ← 1 and go to SHIFT.
- SHIFT:
  - sclk toggles every CLK_DIV cycles.
  - On each fall, after rises 1–15: shift left and drive the next bit on mosi.
  - On the fall after rise 16: pulse word_done.
    - If the FIFO is non-empty: pop, drive the new bit15, and stay in SHIFT. This is a burst: active stays high, the next rise comes CLK_DIV later, and there is no extra gap.
    - Otherwise: go to HOLD with mosi ← 0.
- Timing for one word pushed at edge N:
  - Rise k (k = 1..16) at N+1+CLK_DIV+(k−1)·2·CLK_DIV.
  - Last fall and word_done at N+1+32·CLK_DIV.
- HOLD:
  - sclk = 0, active = 1 for CLK_DIV cycles.
  - Then active ← 0 and go to GAP.
  - With CLK_DIV = 4, active falls at N+133.
- GAP:
  - active = 0 for GAP_CYCLES cycles, then IDLE.
  - Words pushed during HOLD or GAP wait; they never shorten the gap.
- Receiver compatibility:
  - Every sclk phase is ≥2 cycles, so the Pico's 2-flop synchronizer sees each edge.
  - Active always rises before the first sclk rise and falls after the last fall.
- Glitch-free outputs: sclk, mosi and active are driven directly from flops.

Decomposition:
- Package com_pkg holds:
  - DATA_W = 16.
  - FSM state localparams (logic [2:0], not enum).
  - Any constants shared with the receive path.
- Sub-module com_tx_fifo: parametric synchronous FIFO with push/pop/full/empty/level; reusable for the receive side later.
- The FSM and serializer stay in com_tx_spi.

Test Plan:
1. Single word: push 0xA5C3 at edge N, CLK_DIV = 4.
   - Sampling mosi on each sclk rise yields 1010_0101_1100_0011.
   - Exactly 16 rises; active rises at N+1, word_done at N+129, active falls at N+133.
2. Loopback: connect the outputs to the existing receiver's sclk/mosi/active inputs and push 0x1234 then 0xFFFF.
   - Receiver audio_out shows 0x1234 then 0xFFFF, each with one data_ready pulse.
3. Burst: push 0x0001, 0x8000, 0x0000 on consecutive cycles.
   - active stays high through 48 rises; three word_done pulses spaced 16·CLK_DIV·2 = 128 cycles apart; then a single active fall.
4. Full FIFO: hold tx_valid high with incrementing data.
   - tx_ready drops when fifo_level = 4.
   - Only accepted words are sent, in order, with no duplicates or drops.
5. Reset mid-word: assert reset after the 7th rise.
   - sclk, mosi and active go to 0 the same cycle; fifo_level = 0.
   - After release, pushing 0x5A5A transmits cleanly.
6. Gap enforcement: push a word during HOLD.
   - active stays low for exactly GAP_CYCLES = 4 cycles before rising again.
